qspi_tx_sequencer: RTL

Sequences the TX FIFO (fifo_tx) into the QSPI shift engine for one write/program transfer. On start it pops 32-bit words from the FIFO, splits each into bytes (LSB first), presents them to the shifter over a valid/ready byte stream, and stops after exactly len bytes. It sits between the register/command block, which issues start and len, and the fifo_tx read port plus the serial shift engine.

---
 rtl/qspi_pkg.sv | 22 ++
 rtl/qspi_byte_unpacker.sv | 48 ++++
 rtl/qspi_tx_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the QSPI TX sequencer slice:
//   - default FIFO word width and byte-length width
//   - bytes per FIFO word for the default word width
//   - FSM state encoding (S_IDLE .. S_DONE), visible on the top's debug port
// -----------------------------------------------------------------------------
package qspi_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int LEN_W_DEFAULT  = 16;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/qspi_byte_unpacker.sv
// -----------------------------------------------------------------------------
// qspi_byte_unpacker
// Holds one FIFO word and walks through its bytes, least significant first.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   load          capture word_in and rewind the byte index to 0
//   advance       step to the next byte (ignored when load is high)
//   word_in       FIFO read data
//   byte_out      currently selected byte of the held word
//   last          the selected byte is the final byte of the word
// -----------------------------------------------------------------------------
module qspi_byte_unpacker
    import qspi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] word_in,
    output logic [7:0]        byte_out,
    output logic              last
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // {idx, 3'b000} is the bit offset 8*idx of the selected byte.
    assign byte_out = word_q[{idx_q, 3'b000} +: 8];
    assign last     = (idx_q == IDX_W'(BPW - 1));

endmodule

// File: rtl/qspi_tx_sequencer.sv
// -----------------------------------------------------------------------------
// qspi_tx_sequencer
// Pops 32-bit words from the TX FIFO and feeds them to the shift engine as a
// byte stream (LSB first), stopping after exactly len bytes.
// Optional feature macro: QSPI_TX_SEQ_STALL_TIMEOUT_EN (empty-FIFO stall
// timeout that raises underrun_o and terminates the transfer).
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   start_i, len_i    one-cycle start request and byte count (IDLE only)
//   abort_i           cancel the current transfer (no done_o)
//   fifo_rd_en_o      pop strobe; fifo_rd_data_i is valid the cycle after
//   fifo_rd_data_i    FIFO read data
//   fifo_empty_i      FIFO empty flag
//   byte_valid_o      byte stream valid
//   byte_data_o       byte to the shifter
//   byte_ready_i      shifter ready
//   busy_o            transfer in progress
//   done_o            one-cycle pulse after the last byte is accepted
//   underrun_o        sticky stall-timeout flag, cleared by an accepted start
//   bytes_left_o      bytes not yet accepted
//   dbg_state         current FSM state
//
// Byte stream handshake: a byte transfers on a rising edge where byte_valid_o
// and byte_ready_i are both high; while valid is high and ready is low the
// byte and valid are held unchanged. abort_i (or a stall timeout) in the same
// cycle overrides the transfer, so that byte counts as not sent.
// -----------------------------------------------------------------------------
module qspi_tx_sequencer
    import qspi_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int LEN_W          = LEN_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    input  logic              fifo_empty_i,
    output logic              byte_valid_o,
    output logic [7:0]        byte_data_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o,
    output logic [LEN_W-1:0]  bytes_left_o,
    output state_t            dbg_state
);

    state_t           state_q, state_d;
    logic             rd_en_d, valid_d, done_d, busy_d;
    logic [LEN_W-1:0] left_d;
    logic             load, advance, last_byte;
    logic             handshake, start_ok, timeout;

    assign handshake = byte_valid_o && byte_ready_i;
    assign start_ok  = (state_q == S_IDLE) && start_i && !abort_i;
    assign dbg_state = state_q;

    qspi_byte_unpacker #(.DATA_W(DATA_W)) u_unpacker (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .advance  (advance),
        .word_in  (fifo_rd_data_i),
        .byte_out (byte_data_o),
        .last     (last_byte)
    );

`ifdef QSPI_TX_SEQ_STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    // Counts consecutive POP cycles spent waiting on an empty FIFO; any pop
    // or leaving POP clears it.
    always_comb begin
        stall_d = '0;
        timeout = 1'b0;
        if (state_q == S_POP && !fifo_rd_en_o && fifo_empty_i) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q    <= '0;
            underrun_o <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (start_ok) begin
                underrun_o <= 1'b0;
            end else if (timeout) begin
                underrun_o <= 1'b1;
            end
        end
    end
`else
    assign timeout    = 1'b0;
    // Constant-false; keeps the parameter referenced when the timeout is absent.
    assign underrun_o = (TIMEOUT_CYCLES < 0);
`endif

    // rd_en, valid and done are registered, so each is computed here from the
    // state being entered. A pop is only scheduled when the FIFO is non-empty
    // now; this block is the only reader, so it stays non-empty next cycle.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_o;
        left_d  = bytes_left_o;
        load    = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (len_i != '0) begin
                        state_d = S_POP;
                        busy_d  = 1'b1;
                        left_d  = len_i;
                        rd_en_d = !fifo_empty_i;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_POP: begin
                if (fifo_rd_en_o) begin
                    state_d = S_LOAD;
                end else if (!fifo_empty_i) begin
                    rd_en_d = 1'b1;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_SHIFT;
                valid_d = 1'b1;
            end
            S_SHIFT: begin
                valid_d = 1'b1;
                if (handshake) begin
                    advance = 1'b1;
                    left_d  = bytes_left_o - LEN_W'(1);
                    if (bytes_left_o == LEN_W'(1)) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (last_byte) begin
                        state_d = S_POP;
                        valid_d = 1'b0;
                        rd_en_d = !fifo_empty_i;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort and stall timeout both drop the transfer without done_o.
        if ((abort_i && state_q != S_IDLE) || timeout) begin
            state_d = S_IDLE;
            rd_en_d = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            left_d  = '0;
            load    = 1'b0;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            fifo_rd_en_o <= 1'b0;
            byte_valid_o <= 1'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            bytes_left_o <= '0;
        end else begin
            state_q      <= state_d;
            fifo_rd_en_o <= rd_en_d;
            byte_valid_o <= valid_d;
            done_o       <= done_d;
            busy_o       <= busy_d;
            bytes_left_o <= left_d;
        end
    end

endmodule
